// File: rtl/sub4b_serial.sv
// Bit-serial subtractor: D = A - B - Bi (mod 2^WIDTH), one bit per clock,
// LSB first, with a start/busy/done handshake. D and Bo hold the last
// result until the next completion or reset.
module sub4b_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] rd_nxt;
  logic             last;
  logic             accept;

  // One full-subtractor slice on the current LSBs plus the shifted result.
  always_comb begin
    d_bit  = ra[0] ^ rb[0] ^ br;
    br_nxt = (~ra[0] & rb[0]) | (~ra[0] & br) | (rb[0] & br);
    rd_nxt = {d_bit, rd[WIDTH-1:1]};
    last   = (cnt == LAST);
    accept = start && ((state == IDLE) || (state == DONE));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      rd  <= '0;
      br  <= 1'b0;
      cnt <= '0;
      D   <= '0;
      Bo  <= 1'b0;
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      br  <= br_nxt;
      rd  <= rd_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        D  <= rd_nxt;
        Bo <= br_nxt;
      end
    end else if (accept) begin
      ra  <= A;
      rb  <= B;
      br  <= Bi;
      rd  <= '0;
      cnt <= '0;
    end
  end

endmodule
